// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access, taken-branch redirect with two-slot squash, sticky halt flag.
// One-cycle latency EX/MEM -> MEM/WB; halt_f freezes every register and blocks memory writes.
module mem_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_f,
    input  logic [2:0]    type34,
    input  logic [31:0]   INS34,
    input  logic [31:0]   ALUout34,
    input  logic [31:0]   B34,
    input  logic          cond34,
    output logic [31:0]   ALUout45,
    output logic [31:0]   LMD45,
    output logic [31:0]   INS45,
    output logic [2:0]    type45,
    output logic          take_branch,
    output logic [31:0]   branch_pc,
    output logic          halted,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_HALT   = 3'b101;
    localparam logic [2:0] T_BUBBLE = 3'b111;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] addr;
    logic [1:0]    squash_cnt;
    logic          squashing;
    logic          mem_we;
    logic          taken;
    logic          unused_addr_bits;

    // Byte offset and bits above the memory size are dropped, so addresses wrap.
    assign addr             = ALUout34[AW+1:2];
    assign unused_addr_bits = ^{ALUout34[31:AW+2], ALUout34[1:0]};

    assign squashing = (squash_cnt != 2'd0);
    assign mem_we    = !rst && !halt_f && !squashing && (type34 == T_STORE);
    assign taken     = (type34 == T_BRANCH) && cond34;
    assign dbg_data  = mem[dbg_addr];

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= B34;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUout45    <= '0;
            LMD45       <= '0;
            INS45       <= '0;
            type45      <= T_BUBBLE;
            take_branch <= 1'b0;
            branch_pc   <= '0;
            halted      <= 1'b0;
            squash_cnt  <= 2'd0;
        end else if (!halt_f) begin
            if (squashing) begin
                // Wrong-path slot after a taken branch: retire as a bubble.
                squash_cnt  <= squash_cnt - 2'd1;
                type45      <= T_BUBBLE;
                INS45       <= '0;
                take_branch <= 1'b0;
            end else begin
                ALUout45    <= ALUout34;
                INS45       <= INS34;
                type45      <= type34;
                take_branch <= taken;
                if (taken) begin
                    branch_pc  <= ALUout34;
                    squash_cnt <= 2'd2;
                end
                if (type34 == T_LOAD) begin
                    LMD45 <= mem[addr];
                end
                if (type34 == T_HALT) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit data-memory words.
REQ-002 Parameter AW, default 8, word-address width; DEPTH SHALL equal 2**AW.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 halt_f  input  1  pipeline freeze; when 1 all state holds.
REQ-006 type34  input  3  EX/MEM instruction class: 000 rr_alu, 001 ri_alu, 010 load, 011 store, 100 branch, 101 halt, 111 bubble.
REQ-007 INS34  input  32  EX/MEM instruction word.
REQ-008 ALUout34  input  32  ALU result, or effective address for load/store, or target for branch.
REQ-009 B34  input  32  store data.
REQ-010 cond34  input  1  branch condition (1 = taken).
REQ-011 ALUout45  output  32  registered ALU result to WB.
REQ-012 LMD45  output  32  registered load data to WB.
REQ-013 INS45  output  32  registered instruction word to WB.
REQ-014 type45  output  3  registered class to WB (111 = bubble).
REQ-015 take_branch  output  1  one-cycle redirect pulse to fetch.
REQ-016 branch_pc  output  32  redirect target, valid when take_branch=1.
REQ-017 halted  output  1  sticky halt-retired flag.
REQ-018 dbg_addr  input  AW  debug word address.
REQ-019 dbg_data  output  32  combinational read of mem[dbg_addr].

Function
REQ-020 Word address SHALL be ALUout34[AW+1:2]; bits [1:0] and bits above AW+1 ignored (address wraps modulo DEPTH words).
REQ-021 Latency SHALL be one cycle: inputs sampled at edge N appear on *45 outputs after edge N.
REQ-022 Non-squashed store with halt_f=0: mem[addr] <= B34 at the edge; ALUout45/INS45/type45 updated; LMD45 holds.
REQ-023 Non-squashed load: LMD45 <= mem[addr]; a store at edge N followed by load of same address at edge N+1 SHALL return the stored value.
REQ-024 rr_alu/ri_alu: ALUout45 <= ALUout34, INS45, type45 updated; no memory access.
REQ-025 Non-squashed branch with cond34=1: take_branch <= 1, branch_pc <= ALUout34, squash counter <= 2; cond34=0: take_branch <= 0, no squash.
REQ-026 take_branch SHALL be high for exactly one cycle per taken branch (cleared at the next non-frozen edge).
REQ-027 While squash counter != 0, incoming instruction SHALL be squashed: no memory write, type45 <= 111, INS45 <= 0, no redirect, no halt; counter decrements by 1.
REQ-028 Branch or halt arriving while squash counter != 0 SHALL be squashed like any other class.
REQ-029 Non-squashed halt: type45 <= 101, INS45 <= INS34, halted <= 1; halted stays 1 until rst.
REQ-030 Bubble (111) input: type45 <= 111, no memory or branch side effects.
REQ-031 halt_f=1: no memory write; all outputs, squash counter and halted hold; take_branch holds its value.
REQ-032 halted=1 SHALL NOT block further stage operation; freezing is the job of halt_f.

Reset
REQ-033 On rst: ALUout45, LMD45, INS45, branch_pc = 0; type45 = 111; take_branch = 0; halted = 0; squash counter = 0.
REQ-034 Data memory SHALL NOT be reset; contents persist across rst.
REQ-035 rst asserted mid-squash SHALL clear the counter; first post-reset instruction is not squashed.

Verification
REQ-036 Store B34=0xDEADBEEF, ALUout34=0x10, then load ALUout34=0x10 -> LMD45=0xDEADBEEF one cycle after load; dbg_addr=4 -> dbg_data=0xDEADBEEF.
REQ-037 Store at ALUout34=0x400 (DEPTH=256) -> dbg_addr=0 reads stored data (wrap).
REQ-038 Branch cond34=1, ALUout34=0x40, then two stores, then a store of 0x55 to 0x8 -> take_branch=1 one cycle with branch_pc=0x40; first two stores absent from memory, type45=111; 0x55 written to word 2.
REQ-039 Branch cond34=0 followed by store -> take_branch stays 0, store performed.
REQ-040 halt_f=1 held 3 cycles during store -> memory and outputs unchanged; store completes after release.
REQ-041 Halt instruction -> type45=101, halted=1; rst -> halted=0, type45=111, memory contents preserved.
